ifmap_loader: RTL

IFMAP_LOADER -- requirements
Module: ifmap_loader

---
 rtl/ifmap_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ifmap_loader.sv
// Streams one feature map from a valid/ready source into the active ping-pong bank.
// Define LOADER_CHECKSUM_EN to add a running modulo-2^DATA_WIDTH checksum output.
module ifmap_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FMAP_WORDS = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmission_start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic                  buf_sel,
    output logic                  busy,
    output logic                  load_done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(FMAP_WORDS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    sel_q, sel_d;

    logic handshake;
    logic start_load;
    logic last_word;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (transmission_start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (last_word) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == StLoad);
        busy      = (state_q == StLoad) || (state_q == StDone);
        load_done = (state_q == StDone);
    end

    assign handshake  = s_valid && s_ready;
    assign start_load = (state_q == StIdle) && transmission_start;
    assign last_word  = handshake && (cnt_q == LastIdx);

    // ------------------------------------------------------------ datapath
    always_comb begin
        cnt_d = cnt_q;
        if (start_load) begin
            cnt_d = '0;
        end else if (handshake && !last_word) begin
            // Saturating at the final index keeps the address inside the map.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_en_d   = handshake;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (handshake) begin
            wr_addr_d = cnt_q;
            wr_data_d = s_data;
        end
    end

    // Bank flips as DONE is left, so the consumer sees the new bank afterwards.
    assign sel_d = sel_q ^ (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_d;
        end
    end

    assign buf_wr_en   = wr_en_q;
    assign buf_wr_addr = wr_addr_q;
    assign buf_wr_data = wr_data_q;
    assign buf_sel     = sel_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_load) begin
            sum_d = '0;
        end else if (handshake) begin
            sum_d = sum_q + s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule
